// File: rtl/axis_skid_slice.sv
// Two-entry valid/ready register slice: an output register plus one skid entry.
// Upstream ready is the registered emptiness of the skid entry, so it never depends on m_ready_i.
module axis_skid_slice #(
  parameter int unsigned DATA_W = 513
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid_i,
  output logic              s_ready_o,
  input  logic [DATA_W-1:0] s_data_i,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic [DATA_W-1:0] m_data_o
);

  logic              out_valid_q,  out_valid_d;
  logic [DATA_W-1:0] out_data_q,   out_data_d;
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] skid_data_q,  skid_data_d;
  logic              load_out;
  logic              s_push;

  // Output register refills from the skid entry first to preserve order.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    load_out     = !out_valid_q || m_ready_i;
    s_push       = s_valid_i && !skid_valid_q;
    if (load_out) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        skid_valid_d = 1'b0;
      end else if (s_push) begin
        out_valid_d = 1'b1;
        out_data_d  = s_data_i;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (s_push) begin
      skid_valid_d = 1'b1;
      skid_data_d  = s_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end

  assign s_ready_o = !skid_valid_q;
  assign m_valid_o = out_valid_q;
  assign m_data_o  = out_data_q;

endmodule

// File: rtl/fifo_axis_source.sv
// Drains a first-word-fall-through FIFO read port into a framed AXI-Stream master.
// Frames are delimited at pop time; a frame-aligned enable and a completed-frame counter sit on top.
module fifo_axis_source #(
  parameter  int unsigned WIDTH      = 512,
  parameter  int unsigned PKT_WORDS  = 16,
  localparam int unsigned KEEP_WIDTH = WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      fifo_data,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic                  enable,
  output logic [WIDTH-1:0]      m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  busy,
  output logic [31:0]           frame_count
);

  localparam int unsigned CNT_W    = (PKT_WORDS > 1) ? $clog2(PKT_WORDS) : 1;
  localparam int unsigned PAYLOAD_W = WIDTH + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PKT_WORDS - 1);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_RUN      = 2'd1;
  localparam logic [1:0] ST_STOPPING = 2'd2;

  logic [1:0]           state_q,       state_d;
  logic [CNT_W-1:0]     pop_cnt_q,     pop_cnt_d;
  logic [31:0]          frame_count_q, frame_count_d;
  logic                 skid_ready;
  logic                 pop;
  logic                 pop_last;
  logic                 out_valid;
  logic [PAYLOAD_W-1:0] out_payload;

  // The stop decision looks at the post-pop count so a pop in the same cycle never strands a frame.
  always_comb begin
    state_d       = state_q;
    pop_cnt_d     = pop_cnt_q;
    frame_count_d = frame_count_q;
    pop           = !rst && !fifo_empty && skid_ready &&
                    (state_q == ST_RUN || state_q == ST_STOPPING);
    pop_last      = (pop_cnt_q == LAST_CNT);

    if (pop) begin
      pop_cnt_d = pop_last ? '0 : pop_cnt_q + CNT_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!enable) state_d = (pop_cnt_d == '0) ? ST_IDLE : ST_STOPPING;
      end
      ST_STOPPING: begin
        if (enable)                  state_d = ST_RUN;
        else if (pop_cnt_d == '0)    state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (out_valid && m_axis_tready && out_payload[WIDTH]) begin
      frame_count_d = frame_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      pop_cnt_q     <= '0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pop_cnt_q     <= pop_cnt_d;
      frame_count_q <= frame_count_d;
    end
  end

  axis_skid_slice #(
    .DATA_W (PAYLOAD_W)
  ) u_slice (
    .clk       (clk),
    .rst       (rst),
    .s_valid_i (pop),
    .s_ready_o (skid_ready),
    .s_data_i  ({pop_last, fifo_data}),
    .m_valid_o (out_valid),
    .m_ready_i (m_axis_tready),
    .m_data_o  (out_payload)
  );

  assign fifo_rd_en    = pop;
  assign m_axis_tdata  = out_payload[WIDTH-1:0];
  assign m_axis_tlast  = out_payload[WIDTH];
  assign m_axis_tvalid = out_valid;
  assign m_axis_tkeep  = '1;
  assign busy          = (state_q != ST_IDLE) || out_valid || !skid_ready;
  assign frame_count   = frame_count_q;

endmodule

// File: doc/fifo_axis_source.md
# fifo_axis_source

Read-side drain stage for the 512-bit clock-crossing FIFO. It pops words from the FIFO's first-word-fall-through read port (`fifo_data`/`fifo_empty`/`fifo_rd_en`) and presents them as an AXI-Stream master in the read clock domain. The stream is framed into fixed-length packets of `PKT_WORDS` beats, a two-entry skid buffer gives full throughput under backpressure, and a frame-aligned enable plus frame counter support software control.

## Interface
Parameters:
- `WIDTH`, 512, data width in bits; equals the FIFO `WIDTH`.
- `PKT_WORDS`, 16, beats per frame (≥1); `tlast` on every `PKT_WORDS`-th beat.
- `KEEP_WIDTH`, `WIDTH/8`, derived localparam, not overridable.

Ports:
- `clk`  in  1  single clock, the FIFO read clock.
- `rst`  in  1  synchronous, active-high reset.
- `fifo_data`  in  WIDTH  FIFO head word; valid whenever `fifo_empty`=0.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_rd_en`  out  1  pop strobe; head advances at the next `clk` edge.
- `enable`  in  1  level; 1 = drain FIFO, 0 = stop at the next frame boundary.
- `m_axis_tdata`  out  WIDTH  stream data.
- `m_axis_tkeep`  out  KEEP_WIDTH  constant all ones.
- `m_axis_tvalid`  out  1  stream valid.
- `m_axis_tready`  in  1  stream ready.
- `m_axis_tlast`  out  1  last beat of the frame.
- `busy`  out  1  state ≠ IDLE, or any skid/output entry is occupied.
- `frame_count`  out  32  count of completed frames (tlast handshakes); wraps.

## Operation
- Pop control FSM, with a pop beat counter `pop_cnt` (width `max(1,$clog2(PKT_WORDS))`, wraps at `PKT_WORDS-1` to 0).
  - IDLE → RUN when `enable`=1.
  - RUN → STOPPING when `enable`=0 and `pop_cnt`≠0.
  - RUN → IDLE when `enable`=0 and `pop_cnt`=0.
  - STOPPING → IDLE on the pop that wraps `pop_cnt` to 0.
  - STOPPING → RUN if `enable` returns to 1 before the wrap.
- `fifo_rd_en` = `!rst && !fifo_empty && !skid_valid && (state==RUN || state==STOPPING)`. It is combinational from registered state and `fifo_empty`. It must never assert while `fifo_empty`=1.
- On a pop, capture `fifo_data` in the same cycle, tagged with `last = (pop_cnt==PKT_WORDS-1)`. Frames are delimited at pop time, so backpressure cannot shift `tlast`.
- Output register loads when `!m_axis_tvalid || m_axis_tready`. The source is the skid entry if occupied, else the popped word. If the output register cannot load, the popped word goes to the skid entry.
- AXI-Stream rules:
  - `tdata`/`tlast` are held stable while `tvalid && !tready`.
  - `tvalid` never drops without a handshake.
- `frame_count` increments on each cycle with `tvalid && tready && tlast`.
- Words already popped when `enable` falls are always delivered. Only popping stops.

## Timing
- Latency: a word at the FIFO head with `fifo_empty`=0 in cycle N (output stage empty) appears on `m_axis_tvalid` in cycle N+1.
- Throughput: 1 beat/cycle with `tready`=1 and FIFO non-empty.
- Backpressure: at most 2 words are buffered (output + skid). Popping resumes the cycle after the skid drains.
- Reset values: `m_axis_tvalid`=0, `m_axis_tlast`=0, `m_axis_tdata`=0, `fifo_rd_en`=0, `busy`=0, `frame_count`=0, state IDLE, `pop_cnt`=0, skid empty.
- Reset mid-frame discards buffered words and restarts framing at beat 0. Resetting the FIFO is the integrator's responsibility.
- With `PKT_WORDS`=1, every beat has `tlast`=1.
- `fifo_empty` rising in the same cycle as a pop decision: no pop that cycle.

## Structure
- No shared package. `KEEP_WIDTH` and the counter width are local derived constants. FSM state encodings are localparams in this module.
- One sub-module: `axis_skid_slice`, a generic 2-entry register slice on `{last,data}` with valid/ready. Its upstream ready is the registered `!skid_valid`. The top module holds the FSM, `pop_cnt`, `frame_count` and `busy`.

## Test plan
- Preload 32 words (values 0..31), `PKT_WORDS`=16, `enable`=1, `tready`=1 → 32 consecutive beats with `tdata`=0..31, `tlast` on beats 15 and 31, `frame_count`=2, `busy`=0 after drain.
- Same preload, `tready` toggling randomly 50% → data order intact, `tdata`/`tlast` stable during stalls, no pop while skid full, `fifo_rd_en` never high with `fifo_empty`=1.
- Drop `enable` after 5 pops → pops continue to 16, then stop. Exactly 16 beats are output with `tlast` on the 16th; 16 words remain in the FIFO.
- FIFO runs empty mid-frame (8 words), then 8 more words are written → one 16-beat frame, `tlast` only on beat 16, `tvalid` gaps permitted.
- `rst` pulsed with 2 words buffered and `tready`=0 → next cycle `tvalid`=0, `frame_count`=0. The following frame starts at beat 0 and has `tlast` after 16 beats.
- `PKT_WORDS`=1, 4 words → 4 beats, each with `tlast`=1; `frame_count`=4.
